shake256_squeeze: RTL and testbench

- Output (squeeze) end of the SHAKE256 datapath. The pad block feeds rate-sized blocks into absorption; this block drains rate blocks coming out of the Keccak core.
- It serializes each 1088-bit rate block into W-bit output words and truncates the output to a requested byte length.
- When a block is exhausted and more output is needed, it requests another permutation from the core.
- It sits between the Keccak state register and the downstream stream consumer.

---
 rtl/shake_pkg.sv | 27 ++
 rtl/squeeze_word_mux.sv | 38 +++
 rtl/shake256_squeeze.sv | 109 ++++++++++
 tb/tb_shake256_squeeze.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared constants, FSM state type and byte-enable helper for the SHAKE256 squeeze path.
package shake_pkg;

    localparam int RATE_BITS  = 1088;
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int KEEP_MAX   = 64;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        EMIT,
        REQ,
        FIN
    } state_t;

    // MSB-first byte enable: bits [wbytes-1 -: nbytes] set, everything else clear.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned nbytes,
                                                      input int unsigned wbytes);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < wbytes && i + nbytes >= wbytes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/squeeze_word_mux.sv
// Selects the current output word from the rate buffer and trims it to the bytes still owed.
module squeeze_word_mux
    import shake_pkg::*;
#(
    parameter int RATE  = RATE_BITS,
    parameter int W     = 64,
    parameter int LEN_W = 16,
    parameter int IDX_W = $clog2(RATE / W),
    parameter int NB_W  = $clog2(W / 8) + 1
) (
    input  logic             en,
    input  logic [RATE-1:0]  buffer,
    input  logic [IDX_W-1:0] word_idx,
    input  logic [LEN_W-1:0] remaining,
    output logic [W-1:0]     data,
    output logic [W/8-1:0]   keep,
    output logic             last,
    output logic [NB_W-1:0]  nbytes
);

    localparam int KB = W / 8;

    logic [W-1:0] word;

    assign word   = buffer[RATE-1-W*int'(word_idx) -: W];
    assign nbytes = (remaining >= LEN_W'(KB)) ? NB_W'(KB) : NB_W'(remaining);
    assign keep   = en ? KB'(keep_mask(32'(nbytes), KB)) : '0;
    assign last   = en && (remaining <= LEN_W'(KB));

    // NOTE: defaulting every always_comb output before any branch keeps it from inferring a latch.
    always_comb begin
        data = '0;
        for (int b = 0; b < KB; b++) begin
            if (keep[b]) data[8*b +: 8] = word[8*b +: 8];
        end
    end

endmodule

// File: rtl/shake256_squeeze.sv
// Squeeze side of SHAKE256: serialises permuted rate blocks into W-bit words, truncated to out_len bytes.
module shake256_squeeze
    import shake_pkg::*;
#(
    parameter int RATE  = RATE_BITS,
    parameter int W     = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [RATE-1:0]  blk_data,
    output logic             perm_req,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [W-1:0]     dout_data,
    output logic [W/8-1:0]   dout_keep,
    output logic             dout_last,
    output logic             busy,
    output logic             done
);

    localparam int WPB   = RATE / W;
    localparam int IDX_W = $clog2(WPB);
    localparam int NB_W  = $clog2(W / 8) + 1;

    state_t           state, state_n;
    logic [LEN_W-1:0] remaining;
    logic [IDX_W-1:0] word_idx;
    logic [RATE-1:0]  buffer;
    logic [NB_W-1:0]  nbytes;
    logic             emit_hs;

    squeeze_word_mux #(
        .RATE (RATE),
        .W    (W),
        .LEN_W(LEN_W),
        .IDX_W(IDX_W),
        .NB_W (NB_W)
    ) u_mux (
        .en       (dout_valid),
        .buffer   (buffer),
        .word_idx (word_idx),
        .remaining(remaining),
        .data     (dout_data),
        .keep     (dout_keep),
        .last     (dout_last),
        .nbytes   (nbytes)
    );

    assign emit_hs = (state == EMIT) && dout_ready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = (out_len == '0) ? FIN : WAIT_BLK;
            WAIT_BLK: if (blk_valid) state_n = EMIT;
            EMIT: begin
                if (emit_hs) begin
                    if (dout_last)                           state_n = FIN;
                    else if (word_idx == IDX_W'(WPB - 1))    state_n = REQ;
                end
            end
            REQ:      state_n = WAIT_BLK;
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so each one is a clean decode of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            word_idx   <= '0;
            // NOTE: the buffer is cleared on reset so dout_data reads zero until a block is accepted.
            buffer     <= '0;
            blk_ready  <= 1'b0;
            perm_req   <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            state      <= state_n;
            blk_ready  <= (state_n == WAIT_BLK);
            perm_req   <= (state_n == REQ);
            dout_valid <= (state_n == EMIT);
            busy       <= (state_n != IDLE);
            done       <= (state_n == FIN);

            if (state == IDLE && start && out_len != '0) remaining <= out_len;

            if (state == WAIT_BLK && blk_valid) begin
                buffer   <= blk_data;
                word_idx <= '0;
            end

            if (emit_hs) begin
                remaining <= remaining - LEN_W'(nbytes);
                if (!dout_last && word_idx != IDX_W'(WPB - 1)) word_idx <= word_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shake256_squeeze.sv
// Self-checking bench: random rate blocks and lengths checked against a byte-stream model of the output.
module tb_shake256_squeeze;
    import shake_pkg::*;

    localparam int W     = 64;
    localparam int KB    = W / 8;
    localparam int LEN_W = 16;
    localparam int RATE  = RATE_BITS;
    localparam int WPB   = RATE / W;
    localparam int NBLK  = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] out_len = '0;
    logic             blk_valid = 1'b0;
    logic             blk_ready;
    logic [RATE-1:0]  blk_data = '0;
    logic             perm_req;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic [W-1:0]     dout_data;
    logic [KB-1:0]    dout_keep;
    logic             dout_last;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    logic [RATE-1:0] blocks [0:NBLK-1];

    shake256_squeeze #(.RATE(RATE), .W(W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_len   (out_len),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .perm_req  (perm_req),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_keep (dout_keep),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_blocks();
        for (int i = 0; i < NBLK; i++)
            for (int k = 0; k < RATE / 32; k++)
                blocks[i][32*k +: 32] = $urandom();
    endtask

    // The squeezed output is the concatenation of the blocks, each read first byte at the MSB.
    function automatic logic [7:0] stream_byte(input int j);
        logic [RATE-1:0] b;
        b = blocks[j / RATE_BYTES];
        return b[RATE-1-8*(j % RATE_BYTES) -: 8];
    endfunction

    // mode 0: ready high; mode 1: ready 1010...; mode 2: random ready and random blk_valid.
    task automatic do_request(input int len, input int mode, input int rst_at);
        int          words = 0, perms = 0, cyc = 0, done_cyc = -1, blk_idx = 0, nb, budget;
        bit          got_done = 0, stalled = 0, saw_valid = 0, saw_ready = 0, prev_perm = 0, quiet;
        logic [63:0] pdata, ed;
        logic [7:0]  pkeep, ek;
        logic        plast;

        fill_blocks();
        start   = 1'b1;
        out_len = LEN_W'(len);
        @(posedge clk); #1;
        start   = 1'b0;
        budget  = 6 * len + 50;

        while (!got_done && cyc < budget) begin
            dout_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            blk_valid  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            blk_data   = blocks[blk_idx];
            if (dout_valid) saw_valid = 1;
            if (blk_ready)  saw_ready = 1;

            if (rst_at >= 0 && words == rst_at && dout_valid) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_data", dout_data, 64'(0));
                check("rst_ctrl", 64'({dout_keep, dout_last, dout_valid, blk_ready, perm_req, busy, done}), 64'(0));
                quiet = 1;
                repeat (6) begin
                    @(posedge clk); #1;
                    if (dout_valid || done || busy) quiet = 0;
                end
                check("rst_quiet", 64'(quiet), 64'(1));
                return;
            end

            if (stalled) begin
                check("stall_data", dout_data, pdata);
                check("stall_keep", 64'(dout_keep), 64'(pkeep));
                check("stall_last", 64'(dout_last), 64'(plast));
            end
            stalled = dout_valid && !dout_ready;
            pdata = dout_data;
            pkeep = dout_keep;
            plast = dout_last;

            if (dout_valid && dout_ready) begin
                nb = (len - 8 * words < KB) ? len - 8 * words : KB;
                ed = '0;
                ek = '0;
                for (int b = 0; b < nb; b++) begin
                    ed[63-8*b -: 8] = stream_byte(8 * words + b);
                    ek[7-b] = 1'b1;
                end
                check("word_data", dout_data, ed);
                check("word_keep", 64'(dout_keep), 64'(ek));
                check("word_last", 64'(dout_last), 64'(len - 8 * words <= KB));
                words++;
            end

            if (perm_req) begin
                check("perm_single", 64'(prev_perm), 64'(0));
                check("perm_timing", 64'(words == WPB * (perms + 1)), 64'(1));
                perms++;
                blk_idx++;
            end
            prev_perm = perm_req;

            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end

        blk_valid  = 1'b0;
        dout_ready = 1'b0;
        if (!got_done) begin
            check("done_timeout", 64'(0), 64'(1));
        end else begin
            check("word_count", 64'(words), 64'((len + KB - 1) / KB));
            check("perm_count", 64'(perms), 64'((len == 0) ? 0 : (len - 1) / RATE_BYTES));
            check("saw_valid", 64'(saw_valid), 64'(len > 0));
            check("saw_ready", 64'(saw_ready), 64'(len > 0));
            if (len == 0)      check("done_latency0", 64'(done_cyc <= 1), 64'(1));
            else if (mode == 0) check("done_latency", 64'(done_cyc), 64'(1 + words + 2 * perms));
            check("done_pulse", 64'({done, busy}), 64'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", dout_data, 64'(0));
        check("reset_ctrl", 64'({dout_keep, dout_last, dout_valid, blk_ready, perm_req, busy, done}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_request(32, 0, -1);
        do_request(136, 0, -1);
        do_request(137, 0, -1);
        do_request(0, 0, -1);
        do_request(20, 1, -1);
        do_request(64, 0, 4);
        do_request(8, 0, -1);
        do_request(272, 1, -1);

        repeat (6) do_request($urandom_range(1, 1000), $urandom_range(0, 2), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
